// File: rtl/mux_stream_sel.sv
// N-channel registered stream selector: direct (sel) or round-robin scan mode, valid/ready output.
// Optional registered parity output when MUX_PARITY_EN is defined.
module mux_stream_sel #(
    parameter int unsigned N_CH = 8,
    parameter int unsigned DW   = 8,
    localparam int unsigned SW  = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      ch_en,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_ch
`ifdef MUX_PARITY_EN
    ,
    output logic                 out_par
`endif
);

    localparam int unsigned NP = 1 << SW;

    logic [DW-1:0] ch_arr [NP];
    logic          load_c;
    logic [SW-1:0] start_c;
    logic [SW-1:0] hit_c;
    logic          any_c;
    logic [SW:0]   idx_c;

    logic [SW-1:0] ptr, ptr_n;
    logic          mode_q;
    logic          valid_n;
    logic [DW-1:0] data_n;
    logic [SW-1:0] ch_n;

    // Channel table padded to 2**SW entries; indices past N_CH read as zero
    for (genvar k = 0; k < NP; k++) begin : g_ch
        if (k < N_CH) begin : g_real
            assign ch_arr[k] = in_data[k*DW +: DW];
        end else begin : g_pad
            assign ch_arr[k] = '0;
        end
    end

    assign load_c = !out_valid || out_ready;

    // Priority rotate: first enabled channel at or after start_c, wrapping to 0
    always_comb begin
        start_c = (mode && !mode_q) ? '0 : ptr;
        hit_c   = '0;
        any_c   = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx_c = {1'b0, start_c} + (SW+1)'(i);
            if (idx_c >= (SW+1)'(N_CH)) begin
                idx_c = idx_c - (SW+1)'(N_CH);
            end
            if (!any_c && ch_en[idx_c[SW-1:0]]) begin
                any_c = 1'b1;
                hit_c = idx_c[SW-1:0];
            end
        end
    end

    // Next-state: hold everything unless the output stage can load
    always_comb begin
        valid_n = out_valid;
        data_n  = out_data;
        ch_n    = out_ch;
        ptr_n   = ptr;
        if (load_c) begin
            if (!mode) begin
                valid_n = 1'b1;
                data_n  = ch_arr[sel];
                ch_n    = sel;
            end else if (any_c) begin
                valid_n = 1'b1;
                data_n  = ch_arr[hit_c];
                ch_n    = hit_c;
                ptr_n   = (hit_c == SW'(N_CH - 1)) ? '0 : hit_c + SW'(1);
            end else begin
                valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
            mode_q    <= 1'b0;
        end else begin
            out_valid <= valid_n;
            out_data  <= data_n;
            out_ch    <= ch_n;
            ptr       <= ptr_n;
            mode_q    <= mode;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else begin
            out_par <= ^data_n;
        end
    end
`endif

endmodule
